// File: rtl/te_block_serializer.sv
// Trace-encoder block serializer: buffers N-block bundles and
// presents their occupied blocks one at a time over valid/ready.

package mure_pkg;
    localparam int XLEN        = 32;
    localparam int IRETIRE_LEN = 32;
    localparam int ITYPE_LEN   = 3;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;
endpackage

module te_block_serializer
    import mure_pkg::*;
#(
    parameter int N     = 2,
    parameter int DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            valid_i,
    input  logic [N-1:0][IRETIRE_LEN-1:0]   iretire_i,
    input  logic [N-1:0]                    ilastsize_i,
    input  logic [N-1:0][ITYPE_LEN-1:0]     itype_i,
    input  logic [N-1:0][CAUSE_LEN-1:0]     cause_i,
    input  logic [N-1:0][XLEN-1:0]          tval_i,
    input  logic [N-1:0][PRIV_LEN-1:0]      priv_i,
    input  logic [N-1:0][XLEN-1:0]          iaddr_i,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [IRETIRE_LEN-1:0]          iretire_o,
    output logic                            ilastsize_o,
    output logic [ITYPE_LEN-1:0]            itype_o,
    output logic [CAUSE_LEN-1:0]            cause_o,
    output logic [XLEN-1:0]                 tval_o,
    output logic [PRIV_LEN-1:0]             priv_o,
    output logic [XLEN-1:0]                 iaddr_o,
    output logic                            empty_o,
    output logic                            overflow_o,
    output logic [7:0]                      drop_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } blk_t;

    typedef enum logic {IDLE, SEND} state_t;

    blk_t [N-1:0] mem_q  [DEPTH];
    logic [N-1:0] mask_q [DEPTH];

    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] slot_q, nxt_slot;
    state_t        state_q, state_d;
    logic          ovf_q;
    logic [7:0]    drop_q;

    blk_t [N-1:0]  in_blk;
    logic [N-1:0]  in_mask;
    blk_t [N-1:0]  head;
    logic [N-1:0]  hmask;
    blk_t          out_blk;
    logic          has_nxt, xfer, pop, push, drop, full;

    always_comb begin
        in_blk  = '0;
        in_mask = '0;
        for (int j = 0; j < N; j++) begin
            in_blk[j].iretire   = iretire_i[j];
            in_blk[j].ilastsize = ilastsize_i[j];
            in_blk[j].itype     = itype_i[j];
            in_blk[j].cause     = cause_i[j];
            in_blk[j].tval      = tval_i[j];
            in_blk[j].priv      = priv_i[j];
            in_blk[j].iaddr     = iaddr_i[j];
            in_mask[j] = (j == 0) || (|iretire_i[j]) || (|itype_i[j]);
        end
    end

    assign head  = mem_q[rd_q];
    assign hmask = mask_q[rd_q];

    assign valid_o = (state_q == SEND);
    assign xfer    = valid_o & ready_i;

    // Lowest occupied slot above the current one; empty slots cost no cycle
    always_comb begin
        nxt_slot = '0;
        has_nxt  = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (j > int'(slot_q) && hmask[j]) begin
                nxt_slot = SW'(j);
                has_nxt  = 1'b1;
            end
        end
    end

    assign pop   = xfer & ~has_nxt;
    assign full  = (cnt_q == CW'(DEPTH));
    assign push  = valid_i & (~full | pop);
    assign drop  = valid_i & full & ~pop;
    assign cnt_d = cnt_q + CW'(push) - CW'(pop);

    // Next state looks at the post-update count so a push shows next cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cnt_d != '0) state_d = SEND;
            SEND:    if (pop && cnt_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            slot_q  <= '0;
            state_q <= IDLE;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) begin
                rd_q   <= rd_q + 1'b1;
                slot_q <= '0;
            end else if (xfer) begin
                slot_q <= nxt_slot;
            end
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_q]  <= in_blk;
            mask_q[wr_q] <= in_mask;
        end
    end

    assign out_blk     = valid_o ? head[slot_q] : '0;
    assign iretire_o   = out_blk.iretire;
    assign ilastsize_o = out_blk.ilastsize;
    assign itype_o     = out_blk.itype;
    assign cause_o     = out_blk.cause;
    assign tval_o      = out_blk.tval;
    assign priv_o      = out_blk.priv;
    assign iaddr_o     = out_blk.iaddr;

    assign empty_o    = (cnt_q == '0) && (state_q == IDLE);
    assign overflow_o = ovf_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_te_block_serializer.sv
// Bench for te_block_serializer: directed scenarios plus random traffic
// checked against a queue-of-blocks reference model.

module tb_te_block_serializer;
    import mure_pkg::*;

    localparam int N     = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
        logic [XLEN-1:0]        iaddr;
    } blk_t;

    logic clk_i = 1'b0;
    logic rst_i, valid_i, ready_i;
    logic [N-1:0][IRETIRE_LEN-1:0] iretire_i;
    logic [N-1:0]                  ilastsize_i;
    logic [N-1:0][ITYPE_LEN-1:0]   itype_i;
    logic [N-1:0][CAUSE_LEN-1:0]   cause_i;
    logic [N-1:0][XLEN-1:0]        tval_i;
    logic [N-1:0][PRIV_LEN-1:0]    priv_i;
    logic [N-1:0][XLEN-1:0]        iaddr_i;
    logic                          valid_o, empty_o, overflow_o;
    logic [IRETIRE_LEN-1:0]        iretire_o;
    logic                          ilastsize_o;
    logic [ITYPE_LEN-1:0]          itype_o;
    logic [CAUSE_LEN-1:0]          cause_o;
    logic [XLEN-1:0]               tval_o;
    logic [PRIV_LEN-1:0]           priv_o;
    logic [XLEN-1:0]               iaddr_o;
    logic [7:0]                    drop_cnt_o;
    blk_t                          obs_blk;

    int checks = 0;
    int errors = 0;

    blk_t bun [N];
    blk_t exp_q [$];
    int   sizes_q [$];
    bit   m_ovf;
    int   m_drop;

    always #5 clk_i = ~clk_i;

    te_block_serializer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .iretire_i(iretire_i), .ilastsize_i(ilastsize_i),
        .itype_i(itype_i), .cause_i(cause_i), .tval_i(tval_i),
        .priv_i(priv_i), .iaddr_i(iaddr_i),
        .valid_o(valid_o), .ready_i(ready_i),
        .iretire_o(iretire_o), .ilastsize_o(ilastsize_o),
        .itype_o(itype_o), .cause_o(cause_o), .tval_o(tval_o),
        .priv_o(priv_o), .iaddr_o(iaddr_o),
        .empty_o(empty_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o)
    );

    assign obs_blk = {iretire_o, ilastsize_o, itype_o, cause_o,
                      tval_o, priv_o, iaddr_o};

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic blk_t mk(logic [IRETIRE_LEN-1:0] ir,
                                logic [ITYPE_LEN-1:0] it);
        blk_t b;
        b.iretire   = ir;
        b.ilastsize = 1'($urandom);
        b.itype     = it;
        b.cause     = CAUSE_LEN'($urandom);
        b.tval      = XLEN'($urandom);
        b.priv      = PRIV_LEN'($urandom);
        b.iaddr     = XLEN'($urandom);
        return b;
    endfunction

    task automatic rand_bundle();
        for (int j = 0; j < N; j++) begin
            if ($urandom_range(0, 3) == 0)
                bun[j] = mk('0, '0);
            else
                bun[j] = mk(IRETIRE_LEN'($urandom), ITYPE_LEN'($urandom));
        end
    endtask

    task automatic drive();
        for (int j = 0; j < N; j++) begin
            iretire_i[j]   = bun[j].iretire;
            ilastsize_i[j] = bun[j].ilastsize;
            itype_i[j]     = bun[j].itype;
            cause_i[j]     = bun[j].cause;
            tval_i[j]      = bun[j].tval;
            priv_i[j]      = bun[j].priv;
            iaddr_i[j]     = bun[j].iaddr;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        sizes_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic check_outputs();
        bit   ev;
        blk_t e;
        ev = (exp_q.size() != 0);
        e  = ev ? exp_q[0] : '0;
        chk("valid", 128'(valid_o), 128'(ev));
        chk("empty", 128'(empty_o), 128'(!ev));
        chk("overflow", 128'(overflow_o), 128'(m_ovf));
        chk("drop_cnt", 128'(drop_cnt_o), 128'(m_drop));
        chk("block", 128'(obs_blk), 128'(e));
    endtask

    // One clock: check presented outputs, then apply the cycle's effect
    task automatic tick(bit v, bit rdy, bit rst);
        valid_i = v;
        ready_i = rdy;
        rst_i   = rst;
        drive();
        @(negedge clk_i);
        check_outputs();
        @(posedge clk_i);
        if (rst) begin
            model_clear();
        end else begin
            if (exp_q.size() != 0 && rdy) begin
                void'(exp_q.pop_front());
                sizes_q[0]--;
                if (sizes_q[0] == 0) void'(sizes_q.pop_front());
            end
            if (v) begin
                if (sizes_q.size() < DEPTH) begin
                    int n;
                    n = 0;
                    for (int j = 0; j < N; j++) begin
                        if (j == 0 || bun[j].iretire != 0 || bun[j].itype != 0) begin
                            exp_q.push_back(bun[j]);
                            n++;
                        end
                    end
                    sizes_q.push_back(n);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
        #1;
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        for (int j = 0; j < N; j++) bun[j] = mk('0, '0);
        drive();
        repeat (2) @(posedge clk_i);
        #1;
        model_clear();
        chk("rst_valid", 128'(valid_o), 128'(0));
        chk("rst_empty", 128'(empty_o), 128'(1));
        chk("rst_ovf", 128'(overflow_o), 128'(0));
        chk("rst_drop", 128'(drop_cnt_o), 128'(0));
        chk("rst_data", 128'(obs_blk), 128'(0));

        // two occupied slots, consumer always ready
        bun[0] = mk(3, 0);
        bun[1] = mk(5, 0);
        tick(1, 1, 0);
        chk("two_v1", 128'(valid_o), 128'(1));
        chk("two_d1", 128'(iretire_o), 128'(3));
        tick(0, 1, 0);
        chk("two_v2", 128'(valid_o), 128'(1));
        chk("two_d2", 128'(iretire_o), 128'(5));
        tick(0, 1, 0);
        chk("two_empty", 128'(empty_o), 128'(1));
        chk("two_v3", 128'(valid_o), 128'(0));

        // empty slot 1 skipped, next bundle follows without a bubble
        bun[0] = mk(7, 1);
        bun[1] = mk(0, 0);
        tick(1, 1, 0);
        chk("skip_d0", 128'(iretire_o), 128'(7));
        bun[0] = mk(9, 0);
        bun[1] = mk(11, 2);
        tick(1, 1, 0);
        chk("skip_v", 128'(valid_o), 128'(1));
        chk("skip_d1", 128'(iretire_o), 128'(9));
        tick(0, 1, 0);
        chk("skip_d2", 128'(iretire_o), 128'(11));
        tick(0, 1, 0);
        chk("skip_empty", 128'(empty_o), 128'(1));

        // stall three cycles
        bun[0] = mk(21, 0);
        bun[1] = mk(22, 0);
        tick(1, 0, 0);
        repeat (3) tick(0, 0, 0);
        chk("stall_d", 128'(iretire_o), 128'(21));
        tick(0, 1, 0);
        chk("stall_next", 128'(iretire_o), 128'(22));
        tick(0, 1, 0);

        // six pushes into a stalled FIFO of four
        for (int i = 0; i < 6; i++) begin
            bun[0] = mk(IRETIRE_LEN'(100 + i), 0);
            bun[1] = mk(0, 0);
            tick(1, 0, 0);
        end
        chk("ovf_flag", 128'(overflow_o), 128'(1));
        chk("ovf_cnt", 128'(drop_cnt_o), 128'(2));
        chk("ovf_head", 128'(iretire_o), 128'(100));
        repeat (6) tick(0, 1, 0);
        chk("ovf_drained", 128'(empty_o), 128'(1));

        // full FIFO: push with same-cycle pop is accepted
        tick(0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            bun[0] = mk(IRETIRE_LEN'(200 + i), 0);
            bun[1] = mk(0, 0);
            tick(1, 0, 0);
        end
        bun[0] = mk(210, 0);
        tick(1, 1, 0);
        chk("fullpop_drop", 128'(drop_cnt_o), 128'(0));
        chk("fullpop_ovf", 128'(overflow_o), 128'(0));
        bun[0] = mk(211, 0);
        tick(1, 0, 0);
        chk("fullpop_still_full", 128'(drop_cnt_o), 128'(1));
        repeat (6) tick(0, 1, 0);

        // reset in the middle of serialization
        tick(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            rand_bundle();
            tick(1, 0, 0);
        end
        tick(0, 1, 0);
        rand_bundle();
        tick(1, 1, 1);
        chk("mid_rst_valid", 128'(valid_o), 128'(0));
        chk("mid_rst_empty", 128'(empty_o), 128'(1));
        chk("mid_rst_ovf", 128'(overflow_o), 128'(0));
        chk("mid_rst_drop", 128'(drop_cnt_o), 128'(0));
        tick(0, 1, 0);

        // drop counter saturation
        for (int i = 0; i < 262; i++) begin
            rand_bundle();
            tick(1, 0, 0);
        end
        chk("sat_cnt", 128'(drop_cnt_o), 128'(255));
        chk("sat_ovf", 128'(overflow_o), 128'(1));
        tick(0, 0, 1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            rand_bundle();
            tick(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 149) == 0));
        end
        repeat (20) tick(0, 1, 0);
        chk("final_empty", 128'(empty_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
